// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Main FSM for a multicycle RV32I(+M, +Zicsr) datapath.
//               Sequences fetch, decode, address/execute and write-back
//               steps. Each cycle it drives the datapath strobes and the
//               mux selects.
// Ports       : clk, rst          - rising-edge clock, sync active-high reset
//               instr[31:0]       - current instruction register contents
//               mem_ready         - bus completes the access this cycle
//               branch_taken      - ALU compare result
//               muldiv_ready      - mul/div result valid
//               mem_valid, mem_we, ir_we, pc_we, reg_we, adr_src,
//               muldiv_start, csr_we, instr_retired, illegal - strobes
//               alu_src_a, alu_src_b, result_src, alu_op     - mux selects
//               state_o[3:0]      - current state, for debug
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int unsigned RV32M  = 1,
  parameter int unsigned CSR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  input  logic        muldiv_ready,
  output logic        mem_valid,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        adr_src,
  output logic        muldiv_start,
  output logic        csr_we,
  output logic        instr_retired,
  output logic        illegal,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_op,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE_R  = 4'd6,
    S_EXE_I  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_UPPER  = 4'd12,
    S_MULDIV = 4'd13,
    S_CSR    = 4'd14,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  localparam logic w_m_en   = (RV32M  != 0);
  localparam logic w_csr_en = (CSR_EN != 0);

  state_t state_q, state_d;
  logic   started_q, started_d;   // MULDIV start pulse already issued
  logic   retired_q, retired_d;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rs1;
  logic       unused_instr_bits;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_rs1    = instr[19:15];
  assign unused_instr_bits = ^{instr[24:20], instr[11:7]};

  logic       w_mem_valid, w_mem_we, w_ir_we, w_pc_we, w_reg_we, w_adr_src;
  logic       w_muldiv_start, w_csr_we, w_illegal;
  logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src, w_alu_op;

  always_comb begin
    state_d        = state_q;
    started_d      = 1'b0;
    w_mem_valid    = 1'b0;
    w_mem_we       = 1'b0;
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_reg_we       = 1'b0;
    w_adr_src      = 1'b0;
    w_muldiv_start = 1'b0;
    w_csr_we       = 1'b0;
    w_illegal      = 1'b0;
    w_alu_src_a    = 2'd0;
    w_alu_src_b    = 2'd0;
    w_result_src   = 2'd0;
    w_alu_op       = 2'b00;

    case (state_q)
      S_FETCH: begin
        w_mem_valid = 1'b1;
        if (mem_ready) begin
          // PC <= PC + 4 straight from the ALU result
          w_ir_we      = 1'b1;
          w_pc_we      = 1'b1;
          w_alu_src_a  = 2'd2;
          w_alu_src_b  = 2'd2;
          w_result_src = 2'd2;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute oldPC + imm as the branch target
        w_alu_src_a = 2'd1;
        w_alu_src_b = 2'd1;
        case (w_opcode)
          c_OPC_LOAD, c_OPC_STORE: state_d = S_MEMADR;
          c_OPC_OP:                state_d = S_EXE_R;
          c_OPC_OPIMM:             state_d = S_EXE_I;
          c_OPC_BRANCH:            state_d = S_BRANCH;
          c_OPC_JAL:               state_d = S_JAL;
          c_OPC_JALR:              state_d = S_JALR;
          c_OPC_LUI, c_OPC_AUIPC:  state_d = S_UPPER;
          c_OPC_SYSTEM:            state_d = S_CSR;
          default:                 state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_b = 2'd1;
        state_d     = (w_opcode == c_OPC_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_valid = 1'b1;
        w_adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'd1;
        w_reg_we     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_valid = 1'b1;
        w_mem_we    = 1'b1;
        w_adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXE_R: begin
        w_alu_op = 2'b10;
        if (w_funct7 == 7'b0000001) state_d = w_m_en ? S_MULDIV : S_TRAP;
        else                        state_d = S_ALUWB;
      end
      S_EXE_I: begin
        w_alu_src_b = 2'd1;
        w_alu_op    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_we = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_op = 2'b01;
        w_pc_we  = branch_taken;
        state_d  = S_FETCH;
      end
      S_JALR: begin
        w_alu_src_b = 2'd1;
        state_d     = S_JAL;
      end
      S_JAL: begin
        // PC <= target held in ALUout, ALU forms oldPC + 4 for rd
        w_alu_src_a = 2'd1;
        w_alu_src_b = 2'd2;
        w_pc_we     = 1'b1;
        state_d     = S_ALUWB;
      end
      S_UPPER: begin
        // instr[5] separates LUI (0 + imm) from AUIPC (oldPC + imm)
        w_alu_src_a = instr[5] ? 2'd3 : 2'd1;
        w_alu_src_b = 2'd1;
        state_d     = S_ALUWB;
      end
      S_MULDIV: begin
        w_muldiv_start = ~started_q;
        if (muldiv_ready) begin
          w_reg_we     = 1'b1;
          w_result_src = 2'd3;
          state_d      = S_FETCH;
        end else begin
          started_d = 1'b1;
        end
      end
      S_CSR: begin
        if (w_csr_en && (w_funct3 != 3'd0)) begin
          // Set/clear forms with a zero source must not write the CSR
          w_csr_we     = (w_rs1 != 5'd0) || !w_funct3[1];
          w_reg_we     = 1'b1;
          w_result_src = 2'd3;
          state_d      = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Retire pulse shows in the first FETCH cycle after a completed instruction
  assign retired_d = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                     (state_q != S_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      started_q <= 1'b0;
      retired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      retired_q <= retired_d;
    end
  end

  // Reset silences every output combinationally, including mid-stall
  assign mem_valid     = w_mem_valid    & ~rst;
  assign mem_we        = w_mem_we       & ~rst;
  assign ir_we         = w_ir_we        & ~rst;
  assign pc_we         = w_pc_we        & ~rst;
  assign reg_we        = w_reg_we       & ~rst;
  assign adr_src       = w_adr_src      & ~rst;
  assign muldiv_start  = w_muldiv_start & ~rst;
  assign csr_we        = w_csr_we       & ~rst;
  assign instr_retired = retired_q      & ~rst;
  assign illegal       = w_illegal      & ~rst;
  assign alu_src_a     = w_alu_src_a    & {2{~rst}};
  assign alu_src_b     = w_alu_src_b    & {2{~rst}};
  assign result_src    = w_result_src   & {2{~rst}};
  assign alu_op        = w_alu_op       & {2{~rst}};
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. An
//               instruction-level model turns each instruction class into an
//               expected state path and expected per-instruction strobe
//               totals. Two instances are used: default parameters, and
//               RV32M=0 / CSR_EN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready, branch_taken, muldiv_ready;
  logic        use0;   // 1: observe the RV32M=0 / CSR_EN=0 instance

  always #5 clk = ~clk;

  // strobes: 9 mem_valid 8 mem_we 7 ir_we 6 pc_we 5 reg_we 4 adr_src
  //          3 muldiv_start 2 csr_we 1 instr_retired 0 illegal
  wire [9:0] sb1, sb0;
  wire [1:0] a1, a0, b1, b0, r1, r0, o1, o0;
  wire [3:0] q1, q0;
  // {state[21:18], a[17:16], b[15:14], result_src[13:12], alu_op[11:10], strobes[9:0]}
  wire [21:0] ob = use0 ? {q0, a0, b0, r0, o0, sb0} : {q1, a1, b1, r1, o1, sb1};

  multicycle_control_unit dut1 (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .muldiv_ready(muldiv_ready),
    .mem_valid(sb1[9]), .mem_we(sb1[8]), .ir_we(sb1[7]), .pc_we(sb1[6]),
    .reg_we(sb1[5]), .adr_src(sb1[4]), .muldiv_start(sb1[3]), .csr_we(sb1[2]),
    .instr_retired(sb1[1]), .illegal(sb1[0]),
    .alu_src_a(a1), .alu_src_b(b1), .result_src(r1), .alu_op(o1), .state_o(q1)
  );

  multicycle_control_unit #(.RV32M(0), .CSR_EN(0)) dut0 (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .muldiv_ready(muldiv_ready),
    .mem_valid(sb0[9]), .mem_we(sb0[8]), .ir_we(sb0[7]), .pc_we(sb0[6]),
    .reg_we(sb0[5]), .adr_src(sb0[4]), .muldiv_start(sb0[3]), .csr_we(sb0[2]),
    .instr_retired(sb0[1]), .illegal(sb0[0]),
    .alu_src_a(a0), .alu_src_b(b0), .result_src(r0), .alu_op(o0), .state_o(q0)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit prev_ret = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected path: state, mem_ready, muldiv_ready per cycle (2 = don't care)
  int p_st[$];
  int p_mr[$];
  int p_md[$];

  task automatic push(input int s, input int m, input int d);
    p_st.push_back(s);
    p_mr.push_back(m);
    p_md.push_back(d);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    mem_ready    = 1'($urandom_range(0, 1));
    muldiv_ready = 1'($urandom_range(0, 1));
    branch_taken = 1'($urandom_range(0, 1));
    #4;
    check("rst_outputs_quiet", 32'(ob[17:0]), 32'd0);
    step();
    rst      = 1'b0;
    prev_ret = 1'b0;
  endtask

  // Called at posedge+1 with the selected DUT at the start of FETCH.
  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm,
                           input int wd, input logic bt);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [21:0] v;
    bit m_on, c_on, trap, is_ld, is_st, is_mul, is_csr;
    int e_reg, e_pc, e_mv, e_mls, e_csr, e_rs;
    int c_reg, c_pc, c_mv, c_mwe, c_adr, c_start, c_csr, c_ir, c_ill, c_quiet, c_ret, rs_seen;

    op = ins[6:0]; f3 = ins[14:12]; rs1 = ins[19:15];
    m_on = !use0; c_on = !use0;
    trap = 0; is_ld = 0; is_st = 0; is_mul = 0; is_csr = 0;
    p_st.delete(); p_mr.delete(); p_md.delete();

    for (int k = 0; k < wf; k++) push(0, 0, 2);
    push(0, 1, 2);
    push(1, 2, 2);
    case (op)
      OPC_LOAD: begin
        is_ld = 1; push(2, 2, 2);
        for (int k = 0; k < wm; k++) push(3, 0, 2);
        push(3, 1, 2); push(4, 2, 2);
      end
      OPC_STORE: begin
        is_st = 1; push(2, 2, 2);
        for (int k = 0; k < wm; k++) push(5, 0, 2);
        push(5, 1, 2);
      end
      OPC_OP: begin
        push(6, 2, 2);
        if (ins[31:25] == 7'b0000001) begin
          if (m_on) begin
            is_mul = 1;
            for (int k = 0; k < wd; k++) push(13, 2, 0);
            push(13, 2, 1);
          end else trap = 1;
        end else push(8, 2, 2);
      end
      OPC_OPIMM:  begin push(7, 2, 2); push(8, 2, 2); end
      OPC_BRANCH: push(9, 2, 2);
      OPC_JAL:    begin push(10, 2, 2); push(8, 2, 2); end
      OPC_JALR:   begin push(11, 2, 2); push(10, 2, 2); push(8, 2, 2); end
      OPC_LUI, OPC_AUIPC: begin push(12, 2, 2); push(8, 2, 2); end
      OPC_SYSTEM: begin
        push(14, 2, 2);
        if (c_on && f3 != 3'd0) is_csr = 1;
        else trap = 1;
      end
      default: trap = 1;
    endcase
    if (trap) for (int k = 0; k < 4; k++) push(15, 2, 2);

    e_reg = (trap || is_st || op == OPC_BRANCH) ? 0 : 1;
    e_pc  = 1 + ((op == OPC_BRANCH && bt) ? 1 : 0) + ((op == OPC_JAL || op == OPC_JALR) ? 1 : 0);
    e_mls = (is_ld || is_st) ? wm + 1 : 0;
    e_mv  = wf + 1 + e_mls;
    e_csr = (is_csr && (rs1 != 5'd0 || !f3[1])) ? 1 : 0;
    e_rs  = is_ld ? 1 : ((is_mul || is_csr) ? 3 : 0);

    c_reg = 0; c_pc = 0; c_mv = 0; c_mwe = 0; c_adr = 0; c_start = 0;
    c_csr = 0; c_ir = 0; c_ill = 0; c_quiet = 0; c_ret = 0; rs_seen = -1;

    for (int i = 0; i < p_st.size(); i++) begin
      instr        = ins;
      branch_taken = bt;
      mem_ready    = (p_mr[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(p_mr[i]);
      muldiv_ready = (p_md[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(p_md[i]);
      #4;
      v = ob;
      check("state", 32'(v[21:18]), 32'(p_st[i]));
      if (i == 0) check("retired_at_fetch", 32'(v[1]), 32'(prev_ret));
      else        c_ret += int'(v[1]);
      c_mv    += int'(v[9]);
      c_mwe   += int'(v[8]);
      c_ir    += int'(v[7]);
      c_pc    += int'(v[6]);
      c_reg   += int'(v[5]);
      c_adr   += int'(v[4]);
      c_start += int'(v[3]);
      c_csr   += int'(v[2]);
      if (v[5]) rs_seen = int'(v[13:12]);
      if (p_st[i] == 12) check("upper_src_a", 32'(v[17:16]), ins[5] ? 32'd3 : 32'd1);
      if (p_st[i] == 9)  check("branch_alu_op", 32'(v[11:10]), 32'd1);
      if (p_st[i] == 15) begin
        c_ill += int'(v[0]);
        if ({v[17:10], v[9:1]} != 17'd0) c_quiet++;
      end
      step();
    end

    check("ir_we_count", 32'(c_ir), 32'd1);
    check("pc_we_count", 32'(c_pc), 32'(e_pc));
    check("reg_we_count", 32'(c_reg), 32'(e_reg));
    check("mem_valid_cycles", 32'(c_mv), 32'(e_mv));
    check("mem_we_cycles", 32'(c_mwe), is_st ? 32'(e_mls) : 32'd0);
    check("adr_src_cycles", 32'(c_adr), 32'(e_mls));
    check("muldiv_start_count", 32'(c_start), is_mul ? 32'd1 : 32'd0);
    check("csr_we_count", 32'(c_csr), 32'(e_csr));
    check("retired_mid_instr", 32'(c_ret), 32'd0);
    if (e_reg == 1) check("wb_result_src", 32'(rs_seen), 32'(e_rs));
    if (trap) begin
      check("illegal_cycles", 32'(c_ill), 32'd4);
      check("trap_other_quiet", 32'(c_quiet), 32'd0);
      do_reset();
    end else begin
      prev_ret = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:  r[6:0] = OPC_LOAD;
      1:  r[6:0] = OPC_STORE;
      2:  begin r[6:0] = OPC_OP; r[31:25] = ($urandom_range(0, 1) == 1) ? 7'd1 : 7'd0; end
      3:  r[6:0] = OPC_OPIMM;
      4:  r[6:0] = OPC_BRANCH;
      5:  r[6:0] = OPC_JAL;
      6:  r[6:0] = OPC_JALR;
      7:  r[6:0] = OPC_LUI;
      8:  r[6:0] = OPC_AUIPC;
      9, 10: begin
        r[6:0] = OPC_SYSTEM;
        if ($urandom_range(0, 2) == 0) r[19:15] = 5'd0;
        if ($urandom_range(0, 3) == 0) r[14:12] = 3'd0;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++)
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst = 1'b1; instr = 32'd0; mem_ready = 1'b0; branch_taken = 1'b0;
    muldiv_ready = 1'b0; use0 = 1'b0;
    step();
    do_reset();

    run_instr(32'h00500093, 0, 0, 0, 1'b0);  // addi x1,x0,5
    run_instr(32'h0000a103, 0, 3, 0, 1'b0);  // lw, 3 wait cycles
    run_instr(32'h00208463, 0, 0, 0, 1'b0);  // beq not taken
    run_instr(32'h00208463, 0, 0, 0, 1'b1);  // beq taken
    run_instr(32'h022080b3, 0, 0, 4, 1'b0);  // mul, ready in 5th cycle
    run_instr(32'h022080b3, 1, 0, 0, 1'b0);  // mul, ready immediately
    run_instr(32'h0020a023, 2, 0, 0, 1'b0);  // sw
    run_instr(32'h008000ef, 0, 0, 0, 1'b0);  // jal
    run_instr(32'h000080e7, 0, 0, 0, 1'b0);  // jalr
    run_instr(32'h123450b7, 0, 0, 0, 1'b0);  // lui
    run_instr(32'h12345097, 0, 0, 0, 1'b0);  // auipc
    run_instr(32'h30009073, 0, 0, 0, 1'b0);  // csrrw x0,mstatus,x1
    run_instr(32'h300020f3, 0, 0, 0, 1'b0);  // csrrs x1,mstatus,x0
    run_instr(32'h00000073, 0, 0, 0, 1'b0);  // ecall -> trap
    run_instr(32'h00000000, 0, 0, 0, 1'b0);  // all-zero -> trap

    // Store interrupted by reset in its second bus stall cycle
    do_reset();
    instr = 32'h0020a023; mem_ready = 1'b1;
    #4; check("sw_fetch_state", 32'(ob[21:18]), 32'd0); step();
    mem_ready = 1'b0;
    #4; check("sw_decode_state", 32'(ob[21:18]), 32'd1); step();
    #4; check("sw_memadr_state", 32'(ob[21:18]), 32'd2); step();
    #4; check("sw_stall1_mem_we", 32'(ob[8]), 32'd1); step();
    rst = 1'b1;
    #4; check("sw_rst_quiet", 32'(ob[17:0]), 32'd0); step();
    rst = 1'b0;
    #4;
    check("after_rst_state", 32'(ob[21:18]), 32'd0);
    check("after_rst_mem_we", 32'(ob[8]), 32'd0);
    check("after_rst_retired", 32'(ob[1]), 32'd0);
    check("after_rst_mem_valid", 32'(ob[9]), 32'd1);
    step();
    prev_ret = 1'b0;

    run_random(60);

    use0 = 1'b1;
    do_reset();
    run_instr(32'h022080b3, 0, 0, 4, 1'b0);  // mul without RV32M -> trap
    run_instr(32'h30009073, 0, 0, 0, 1'b0);  // csr without CSR_EN -> trap
    run_instr(32'h00500093, 0, 0, 0, 1'b0);  // addi still legal
    run_random(15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
